// File: rtl/countdown_decrementer_if.sv
// Control and status bundle for countdown_decrementer. The master side (controller or tester)
// drives the strobes and the load value. The slave side (the counter) returns its status.
interface countdown_decrementer_if #(
    parameter int WIDTH = 4
);
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             decrease;
    logic [WIDTH-1:0] count;
    logic             zero;
    logic             busy;
    logic             done;
    logic             underflow;

    modport master (
        output clear, load, load_value, decrease,
        input  count, zero, busy, done, underflow
    );

    modport slave (
        input  clear, load, load_value, decrease,
        output count, zero, busy, done, underflow
    );
endinterface

// File: rtl/countdown_decrementer.sv
// Loadable down-counter with a one-cycle Done pulse at expiry, an optional auto-reload from the
// last loaded value, and a sticky underflow flag that is raised when the count is decremented past zero.
module countdown_decrementer #(
    parameter int WIDTH       = 4,
    parameter int START       = 1,
    parameter int AUTO_RELOAD = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    countdown_decrementer_if.slave bus
);
    localparam logic [WIDTH-1:0] START_V = WIDTH'(START);
    localparam logic [WIDTH-1:0] ZERO_V  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_V   = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_EXPIRED = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             underflow_q, underflow_d;
    logic             done_q, done_d;
    logic             busy_q;

    // Next-state logic. Clear has priority over Load, and Load has priority over Decrease.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        reload_d    = reload_q;
        underflow_d = underflow_q;
        done_d      = 1'b0;
        if (bus.clear) begin
            state_d     = ST_IDLE;
            count_d     = START_V;
            underflow_d = 1'b0;
        end else if (bus.load) begin
            reload_d = bus.load_value;
            count_d  = bus.load_value;
            if (bus.load_value != ZERO_V) begin
                state_d = ST_RUN;
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    count_d = count_q;
                end
                ST_RUN: begin
                    if (bus.decrease) begin
                        if (count_q > ONE_V) begin
                            count_d = count_q - ONE_V;
                        end else begin
                            // Reaching zero (or finding it) ends the run; never wrap.
                            count_d = ZERO_V;
                            state_d = ST_EXPIRED;
                            done_d  = (count_q == ONE_V);
                        end
                    end else begin
                        count_d = count_q;
                    end
                end
                ST_EXPIRED: begin
                    if (bus.decrease) begin
                        if (AUTO_RELOAD != 0) begin
                            if (reload_q > ONE_V) begin
                                count_d = reload_q - ONE_V;
                                state_d = ST_RUN;
                            end else begin
                                // A reload value of 1 expires again immediately.
                                count_d = ZERO_V;
                                done_d  = (reload_q == ONE_V);
                            end
                        end else begin
                            underflow_d = 1'b1;
                        end
                    end else begin
                        count_d = ZERO_V;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = START_V;
                end
            endcase
        end
    end

    // State and output registers. All of them are forced to their reset values while rst_ni is low.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            count_q     <= START_V;
            reload_q    <= START_V;
            underflow_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            reload_q    <= reload_d;
            underflow_q <= underflow_d;
            done_q      <= done_d;
            busy_q      <= (state_d == ST_RUN);
        end
    end

    assign bus.count     = count_q;
    assign bus.zero      = (count_q == ZERO_V);
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.underflow = underflow_q;
endmodule
